// File: rtl/ir_beacon_detector.sv
// Goal-beacon classifier: times rising-edge periods of the synchronised IR pin and
// locks onto the 1 kHz or 10 kHz beacon after MATCH_N consecutive in-window periods.
module ir_beacon_detector #(
  parameter int P1K_MIN  = 90_000,
  parameter int P1K_MAX  = 110_000,
  parameter int P10K_MIN = 9_000,
  parameter int P10K_MAX = 11_000,
  parameter int MATCH_N  = 4,
  parameter int TIMEOUT  = 250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IR_In,
  output logic        IR_1k,
  output logic        IR_10k,
  output logic [17:0] Last_Period
);

  localparam logic [17:0] P1K_MIN_C  = 18'(P1K_MIN);
  localparam logic [17:0] P1K_MAX_C  = 18'(P1K_MAX);
  localparam logic [17:0] P10K_MIN_C = 18'(P10K_MIN);
  localparam logic [17:0] P10K_MAX_C = 18'(P10K_MAX);
  localparam logic [17:0] TIMEOUT_C  = 18'(TIMEOUT);
  localparam logic [17:0] CNT_MAX_C  = 18'h3FFFF;
  localparam logic [2:0]  MATCH_C    = 3'(MATCH_N);

  typedef enum logic {NO_SIG = 1'b0, MEASURE = 1'b1} state_t;
  typedef enum logic [1:0] {CLS_NONE = 2'd0, CLS_1K = 2'd1, CLS_10K = 2'd2} cls_t;

  logic        s1_r, s2_r, s3_r;
  logic        re_s, timeout_s;
  logic [17:0] cnt_r;
  state_t      state_r;
  cls_t        cls_s, last_cls_r;
  logic [2:0]  mcnt_r, mcnt_next_s;
  logic        ir_1k_r, ir_10k_r;
  logic [17:0] last_period_r;

  assign re_s      = s2_r & ~s3_r;
  assign timeout_s = (cnt_r >= TIMEOUT_C);

  assign IR_1k       = ir_1k_r;
  assign IR_10k      = ir_10k_r;
  assign Last_Period = last_period_r;

  // Classify the current count as a candidate period (only used on an edge).
  always_comb begin
    cls_s = CLS_NONE;
    if ((cnt_r >= P1K_MIN_C) && (cnt_r <= P1K_MAX_C)) begin
      cls_s = CLS_1K;
    end else if ((cnt_r >= P10K_MIN_C) && (cnt_r <= P10K_MAX_C)) begin
      cls_s = CLS_10K;
    end else begin
      cls_s = CLS_NONE;
    end
  end

  // Next match count: saturating run length of identical non-NONE classes.
  always_comb begin
    mcnt_next_s = 3'd0;
    if (cls_s == CLS_NONE) begin
      mcnt_next_s = 3'd0;
    end else if (cls_s != last_cls_r) begin
      mcnt_next_s = 3'd1;
    end else if (mcnt_r >= MATCH_C) begin
      mcnt_next_s = MATCH_C;
    end else begin
      mcnt_next_s = mcnt_r + 3'd1;
    end
  end

  // Pin synchroniser, edge register and saturating period counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r  <= 1'b0;
      s2_r  <= 1'b0;
      s3_r  <= 1'b0;
      cnt_r <= 18'd0;
    end else begin
      s1_r <= IR_In;
      s2_r <= s1_r;
      s3_r <= s2_r;
      if (re_s) begin
        cnt_r <= 18'd1;
      end else if (cnt_r != CNT_MAX_C) begin
        cnt_r <= cnt_r + 18'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Lock state machine with registered flags; an edge always beats the timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= NO_SIG;
      mcnt_r        <= 3'd0;
      last_cls_r    <= CLS_NONE;
      ir_1k_r       <= 1'b0;
      ir_10k_r      <= 1'b0;
      last_period_r <= 18'd0;
    end else begin
      case (state_r)
        NO_SIG: begin
          if (re_s) begin
            state_r <= MEASURE;
          end else begin
            state_r <= NO_SIG;
          end
        end
        MEASURE: begin
          if (re_s) begin
            last_period_r <= cnt_r;
            mcnt_r        <= mcnt_next_s;
            last_cls_r    <= cls_s;
            ir_1k_r       <= (mcnt_next_s == MATCH_C) && (cls_s == CLS_1K);
            ir_10k_r      <= (mcnt_next_s == MATCH_C) && (cls_s == CLS_10K);
          end else if (timeout_s) begin
            state_r    <= NO_SIG;
            mcnt_r     <= 3'd0;
            last_cls_r <= CLS_NONE;
            ir_1k_r    <= 1'b0;
            ir_10k_r   <= 1'b0;
          end else begin
            state_r <= MEASURE;
          end
        end
        default: begin
          state_r    <= NO_SIG;
          mcnt_r     <= 3'd0;
          last_cls_r <= CLS_NONE;
          ir_1k_r    <= 1'b0;
          ir_10k_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule
